mux_scan_ctrl: RTL
==================

Name: mux_scan_ctrl

Overview:
- Sequencer that sits directly upstream and downstream of the 4-input 1-bit multiplexer.
- Drives the mux select S through channels 0..3 and waits a programmable settle time on each channel.
- Samples the mux output once per channel and assembles the four bits into a 4-bit word, reported with a start/busy/done handshake.
- Supports single-scan and continuous-scan modes, plus a change-detect flag.

Parameters:
- SETTLE, 1, wait cycles after each S change before sampling mux_out. Legal range 0..15; counter width is 4 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- continuous  input  1  1 = restart immediately after each completed scan; checked at scan completion.
- mux_out  input  1  output of the 4:1 mux under control.
- S  output  2  mux select, registered.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when data is updated.
- data  output  4  last completed scan; bit i = mux_out sampled with S=i.
- changed  output  1  one-cycle pulse, coincident with done, when the new data differs from the previous data.

Behaviour:
- Reset (asynchronous, any time, including mid-scan): state=IDLE, S=0, busy=0, done=0, changed=0, data=0, shadow=0, cnt=0. An aborted scan produces no done and leaves no partial data.
- States:
  - IDLE
    - S holds 0; busy=0.
    - On an edge with start=1: go to SCAN, S<=0, cnt<=SETTLE, busy<=1.
  - SCAN, cnt!=0:
    - cnt<=cnt-1; S holds.
  - SCAN, cnt==0, S<3:
    - shadow[S]<=mux_out; S<=S+1; cnt<=SETTLE.
  - SCAN, cnt==0, S==3 (completion):
    - data<={mux_out, shadow[2:0]}; done<=1.
    - changed<=1 iff the new data != the old data.
    - If continuous=1: stay in SCAN, S<=0, cnt<=SETTLE, busy stays 1.
    - Else: go to IDLE, S<=0, busy<=0.
- Timing:
  - Each channel occupies SETTLE+1 cycles.
  - start captured at edge E0 → channel i sampled at edge E0+(i+1)(SETTLE+1).
  - done is high for exactly the cycle following edge E0+4(SETTLE+1).
  - With SETTLE=0: done follows E0+4.
- Continuous mode: back-to-back scans have no idle gap; the next channel-0 sample occurs SETTLE+1 edges after the completion edge.
- Simultaneous events:
  - start while busy: ignored, not queued.
  - continuous dropped mid-scan: the current scan completes normally, then the block returns to IDLE.
  - continuous=1 with start=0 in IDLE: the block does not start.
- done and changed are registered pulses, never high for two consecutive cycles in single mode. In continuous mode they are separated by at least 4(SETTLE+1)-1 low cycles.
- data is stable between done pulses; shadow bits are never visible on data.
- First scan after reset compares against data=0 (e.g. result 4'b0000 gives changed=0).

Test Plan:
- SETTLE=1; mux inputs a,b,c,d=1,0,1,1; pulse start → S steps 0,1,2,3 holding 2 cycles each; done 8 cycles after start edge; data=4'b1101; changed=1; busy low after done.
- Repeat the same scan with unchanged inputs → data=4'b1101, done pulses, changed=0.
- continuous=1, SETTLE=0, inputs toggling to d=0 during the 2nd scan → done every 4 cycles; second data=4'b0101 with changed=1; drop continuous mid-3rd scan → 3rd scan completes, then IDLE.
- Assert start again during cycle 3 of a scan → no restart; S sequence and done timing unchanged.
- Assert reset asynchronously between clock edges mid-scan at S=2 → S, busy, data, done, changed all 0 immediately; no done afterwards; a subsequent start runs a clean scan.
- SETTLE=15 → each channel holds 16 cycles; done at E0+64; data matches the inputs.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
// Drives the select of a 4:1 one-bit mux through channels 0..3. On each
// channel it waits SETTLE cycles, then samples mux_out. The four samples
// are published together as a 4-bit word with a done pulse. A changed
// pulse fires when the new word differs from the previous one. Scans
// run once per start, or back to back while continuous is held high.

module mux_scan_ctrl #(
   parameter int unsigned SETTLE = 1  // wait cycles per channel, 0..15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       continuous,
   input  logic       mux_out,
   output logic [1:0] S,
   output logic       busy,
   output logic       done,
   output logic [3:0] data,
   output logic       changed
);

   // The settle counter is 4 bits wide. The legal SETTLE range fits
   // without truncation.
   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t     state_q,   state_d;
   logic [1:0] s_q,       s_d;
   logic [3:0] cnt_q,     cnt_d;
   logic [2:0] shadow_q,  shadow_d;
   logic [3:0] data_q,    data_d;
   logic       busy_q,    busy_d;
   logic       done_q,    done_d;
   logic       changed_q, changed_d;

   // Qualifiers for the per-cycle decisions inside SCAN
   logic       sample_now;  // settle time on the current channel has elapsed
   logic       last_ch;     // the current channel is channel 3
   logic       scan_end;    // this edge completes a full 4-channel scan
   logic [3:0] new_word;    // word assembled at completion

   always_comb begin
      sample_now = (state_q == SCAN) && (cnt_q == 4'd0);
      last_ch    = (s_q == 2'd3);
      scan_end   = sample_now && last_ch;
      new_word   = {mux_out, shadow_q};
   end

   // State register: reset can abort a scan at any moment and returns to IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state is always written with <=. Every flop
         // then sees the pre-edge values of the others, which matches the
         // hardware.
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: leave IDLE on start, and return to IDLE only at
   // the end of a non-continuous scan
   always_comb begin
      // NOTE: each always_comb gives every output a default value first.
      // Without it, a path that skips an assignment would infer a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (scan_end && !continuous) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers. The shadow register is also cleared on reset,
   // so an aborted scan leaves no partial sample behind.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_q       <= 2'd0;
         cnt_q     <= 4'd0;
         shadow_q  <= 3'd0;
         data_q    <= 4'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         s_q       <= s_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         changed_q <= changed_d;
      end
   end

   // Datapath next values: settle countdown, channel stepping, sample capture
   // and the completion handshake
   always_comb begin
      s_d       = s_q;
      cnt_d     = cnt_q;
      shadow_d  = shadow_q;
      data_d    = data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      changed_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            s_d    = 2'd0;
            busy_d = 1'b0;
            if (start) begin
               cnt_d  = SETTLE_C;
               busy_d = 1'b1;
            end
         end
         SCAN: begin
            if (cnt_q != 4'd0) begin
               // Still settling on the current channel
               cnt_d = cnt_q - 4'd1;
            end else if (!last_ch) begin
               // Capture channels 0..2 into the shadow, then advance the select
               for (int i = 0; i < 3; i++) begin
                  if (s_q == 2'(i)) begin
                     shadow_d[i] = mux_out;
                  end
               end
               s_d   = s_q + 2'd1;
               cnt_d = SETTLE_C;
            end else begin
               // Channel 3: publish the whole word in one step, so data
               // never exposes a partially assembled scan
               data_d    = new_word;
               done_d    = 1'b1;
               changed_d = (new_word != data_q);
               s_d       = 2'd0;
               cnt_d     = SETTLE_C;
               busy_d    = continuous;
            end
         end
         default: begin
            s_d    = 2'd0;
            cnt_d  = 4'd0;
            busy_d = 1'b0;
         end
      endcase
   end

   // Outputs come straight from flops, so they are glitch-free
   always_comb begin
      S       = s_q;
      busy    = busy_q;
      done    = done_q;
      data    = data_q;
      changed = changed_q;
   end

endmodule
